uart_tx_buffered: RTL and testbench

- Parametrised successor to the fixed 8-bit UART transmit path: a synchronous FIFO feeds a serial transmitter with configurable width, depth, baud divisor, parity mode and stop bits.
- Host-side logic pushes words with wr_en/wr_data. The block drains the FIFO autonomously and sends frames back-to-back on tx.
- Adds fill-level reporting and a sticky overflow flag, which the previous design did not have.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_fifo.sv | 65 ++++++
 rtl/uart_tx_buffered.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and frame helper for the buffered UART transmitter
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    function automatic int frame_bits(input int data_w, input int parity_mode, input int stop_bits);
        return 1 + data_w + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous show-ahead FIFO with registered full/empty/count flags
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic              full_q, empty_q;
    logic              do_push, do_pop;

    // A push while full is dropped even when a pop happens on the same edge.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == (PTR_W+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-fed UART transmitter with configurable framing and sticky overflow
module uart_tx_buffered #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   ovf_clr,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   tx
);
    import uart_pkg::*;

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_TC   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY_MODE != PAR_NONE);

    uart_state_e        state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic               baud_tc, load, pop, parity_bit;
    logic               fifo_full, fifo_empty;
    logic [DATA_W-1:0]  fifo_dout;

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign baud_tc = (baud_q == BAUD_TC);
    // par_q holds the even parity of the word captured at load time.
    assign parity_bit = (PARITY_MODE == PAR_EVEN) ? par_q : ~par_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_tc ? '0 : baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        load    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                load   = !fifo_empty;
            end
            START: if (baud_tc) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
            end
            DATA: if (baud_tc) begin
                if (bit_q == LAST_DATA) begin
                    bit_d = '0;
                    if (HAS_PARITY) begin
                        state_d = PARITY;
                        tx_d    = parity_bit;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_d   = bit_q + BIT_W'(1);
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            PARITY: if (baud_tc) begin
                state_d = STOP;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
            STOP: if (baud_tc) begin
                if (bit_q == LAST_STOP) begin
                    load = !fifo_empty;
                    if (fifo_empty) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Shared by IDLE and the end of STOP so back-to-back frames have no gap.
        if (load) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            par_d   = ^fifo_dout;
            state_d = START;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && fifo_full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - three framing configurations checked cycle-by-cycle against a frame-level model
module tb_uart_tx_buffered;

    localparam int C     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [8:0] wr_data = '0;

    logic       cap_rst = 1'b1, cap_wr = 1'b0, cap_clr = 1'b0;
    logic [8:0] cap_data = '0;

    logic [2:0] tx_v, busy_v, full_v, empty_v, ovf_v;
    logic [2:0] cnt_v [3];

    int errors = 0;
    int checks = 0;

    logic [15:0] fr_bits [3];
    int          blen [3];
    int          falls [3];
    logic [2:0]  prev_busy;
    logic [2:0]  first_tx;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at the rising edge, consumed by the models at the following falling edge.
    initial forever begin
        @(posedge clk);
        cap_rst  = rst;
        cap_wr   = wr_en;
        cap_clr  = ovf_clr;
        cap_data = wr_data;
    end

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int DW = (g == 2) ? 7 : 8;
        localparam int PM = (g == 0) ? 2 : ((g == 1) ? 1 : 0);
        localparam int SB = (g == 1) ? 2 : 1;
        localparam int FL = (1 + DW + ((PM != 0) ? 1 : 0) + SB) * C;

        logic       tx_w, busy_w, full_w, empty_w, ovf_w;
        logic [2:0] count_w;

        uart_tx_buffered #(
            .DATA_W(DW), .DEPTH(DEPTH), .CLKS_PER_BIT(C), .PARITY_MODE(PM), .STOP_BITS(SB)
        ) dut (
            .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data[DW-1:0]), .ovf_clr(ovf_clr),
            .full(full_w), .empty(empty_w), .count(count_w), .overflow(ovf_w),
            .busy(busy_w), .tx(tx_w)
        );

        assign tx_v[g]    = tx_w;
        assign busy_v[g]  = busy_w;
        assign full_v[g]  = full_w;
        assign empty_v[g] = empty_w;
        assign ovf_v[g]   = ovf_w;
        assign cnt_v[g]   = count_w;

        logic [8:0]  mq [$];
        logic [15:0] m_bits;
        logic [7:0]  act_flags, exp_flags;
        int          m_el, pre;
        bit          m_busy, m_ovf, last;

        function automatic logic [15:0] mk_frame(input logic [8:0] d);
            logic [15:0] f = '1;
            logic        p = 1'b0;
            f[0] = 1'b0;
            for (int i = 0; i < DW; i++) begin
                f[1+i] = d[i];
                p ^= d[i];
            end
            if (PM != 0) f[1+DW] = (PM == 1) ? ~p : p;
            return f;
        endfunction

        initial begin
            m_busy = 0; m_ovf = 0; m_el = 0; m_bits = '1;
            forever begin
                @(negedge clk);
                if (rst || cap_rst) begin
                    mq.delete();
                    m_busy = 0; m_ovf = 0; m_el = 0;
                end else begin
                    pre  = mq.size();
                    last = m_busy && (m_el == FL - 1);
                    if (pre > 0 && (!m_busy || last)) begin
                        m_bits = mk_frame(mq.pop_front());
                        m_busy = 1;
                        m_el   = 0;
                    end else if (last) begin
                        m_busy = 0;
                    end else if (m_busy) begin
                        m_el++;
                    end
                    if (cap_wr && pre == DEPTH) m_ovf = 1;
                    else if (cap_clr)           m_ovf = 0;
                    if (cap_wr && pre < DEPTH) mq.push_back(cap_data);
                end
                check($sformatf("cfg%0d tx", g), int'(tx_w), m_busy ? int'(m_bits[m_el / C]) : 1);
                act_flags = {busy_w, full_w, empty_w, ovf_w, 1'b0, count_w};
                exp_flags = {m_busy, mq.size() == DEPTH, mq.size() == 0, m_ovf, 1'b0, 3'(mq.size())};
                check($sformatf("cfg%0d busy/full/empty/ovf/count", g), int'(act_flags), int'(exp_flags));
            end
        end
    end

    task automatic send_one(input logic [8:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        check("tx still idle after write edge", int'(tx_v), 7);
        for (int k = 0; k < 3; k++) begin fr_bits[k] = '1; blen[k] = 0; end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 0) first_tx = tx_v;
            for (int k = 0; k < 3; k++) begin
                if (busy_v[k]) blen[k]++;
                if (c % C == 1) fr_bits[k][c / C] = tx_v[k];
            end
        end
        check("tx falls one edge after write", int'(first_tx), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset tx", int'(tx_v), 7);
        check("reset busy", int'(busy_v), 0);
        check("reset empty", int'(empty_v), 7);
        check("reset full", int'(full_v), 0);
        check("reset overflow", int'(ovf_v), 0);
        check("reset count", int'(cnt_v[0]), 0);

        send_one(9'h0A5);
        check("A5 even-parity frame bits", int'(fr_bits[0][10:0]), 11'b1_0_10100101_0);
        check("busy length even/1stop", blen[0], 44);
        check("busy length odd/2stop", blen[1], 48);
        check("busy length 7bit/none", blen[2], 36);

        send_one(9'h000);
        check("00 odd-parity 2stop frame bits", int'(fr_bits[1][11:0]), 12'b1_1_1_00000000_0);
        check("00 even parity bit", int'(fr_bits[0][9]), 0);

        send_one(9'h07F);
        check("7F 7bit no-parity frame bits", int'(fr_bits[2][8:0]), 9'b1_1111111_0);
        check("7F 7bit frame length", blen[2], 36);

        // Back-to-back frames: busy must never drop between them.
        for (int k = 0; k < 3; k++) begin blen[k] = 0; falls[k] = 0; end
        prev_busy = '0;
        fork
            begin
                @(negedge clk); wr_en = 1'b1; wr_data = 9'h001;
                @(negedge clk); check("b2b count after 1st write", int'(cnt_v[0]), 1); wr_data = 9'h002;
                @(negedge clk); check("b2b count push+pop", int'(cnt_v[0]), 1); wr_data = 9'h003;
                @(negedge clk); check("b2b count after 3rd write", int'(cnt_v[0]), 2); wr_en = 1'b0;
            end
            begin
                for (int c = 0; c < 450; c++) begin
                    @(negedge clk);
                    for (int k = 0; k < 3; k++) begin
                        if (busy_v[k]) blen[k]++;
                        if (prev_busy[k] && !busy_v[k]) falls[k]++;
                    end
                    prev_busy = busy_v;
                end
            end
        join
        check("b2b busy cycles cfg0", blen[0], 132);
        check("b2b busy cycles cfg1", blen[1], 144);
        check("b2b busy cycles cfg2", blen[2], 108);
        check("b2b busy falls cfg0", falls[0], 1);
        check("b2b busy falls cfg2", falls[2], 1);
        check("b2b drained empty", int'(empty_v), 7);

        // Five writes fit (one popped), the sixth overflows.
        @(negedge clk);
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 9'h010 + 9'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("overflow set", int'(ovf_v), 7);
        check("full after overflow", int'(full_v), 7);
        check("count held at depth", int'(cnt_v[0]), 4);
        repeat (5) @(negedge clk);
        check("overflow sticky", int'(ovf_v), 7);
        wr_en = 1'b1; ovf_clr = 1'b1; wr_data = 9'h01F;
        @(negedge clk);
        wr_en = 1'b0;
        check("overflow set wins over clear", int'(ovf_v), 7);
        @(negedge clk);
        ovf_clr = 1'b0;
        check("overflow cleared", int'(ovf_v), 0);
        repeat (300) @(negedge clk);
        check("overflow drained empty", int'(empty_v), 7);
        check("overflow drained idle", int'(busy_v), 0);

        // Reset in the middle of a data bit with words still queued.
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 9'h05A; @(negedge clk);
        wr_data = 9'h011; @(negedge clk);
        wr_data = 9'h022; @(negedge clk);
        wr_data = 9'h033; @(negedge clk);
        wr_en = 1'b0;
        check("queued before reset", int'(cnt_v[0]), 3);
        repeat (10) @(negedge clk);
        check("tx low in data bit before reset", int'(tx_v), 0);
        #1 rst = 1'b1;
        #1;
        check("async reset tx", int'(tx_v), 7);
        check("async reset busy", int'(busy_v), 0);
        check("async reset count", int'(cnt_v[0]), 0);
        check("async reset empty", int'(empty_v), 7);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) blen[k] = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (busy_v[k] || !tx_v[k]) blen[k]++;
        end
        check("no frames after reset cfg0", blen[0], 0);
        check("no frames after reset cfg1", blen[1], 0);
        check("no frames after reset cfg2", blen[2], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
